// File: rtl/garrafas_pkg.sv
// rtl/garrafas_pkg.sv - shared types and constants for the bottle counter
// State encodings, two-digit BCD type and BCD helpers.
package garrafas_pkg;

  typedef enum logic {
    CONTANDO = 1'b0,
    CHEIA    = 1'b1
  } estado_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int MAX_GARRAFAS_PADRAO = 12;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] u;
  } bcd2_t;

  // Units wrap 9->0 with carry into tens; tens wrap as well so no code above 9 appears.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.u == BCD_MAX) begin
      r.u = 4'd0;
      r.d = (v.d == BCD_MAX) ? 4'd0 : v.d + 4'd1;
    end else begin
      r.u = v.u + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t int2bcd(input int n);
    bcd2_t r;
    r.d = 4'(n / 10);
    r.u = 4'(n % 10);
    return r;
  endfunction

endpackage

// File: rtl/modulo_sincroniza_borda.sv
// rtl/modulo_sincroniza_borda.sv - sensor synchroniser, optional debounce, armed rising-edge detect
// Debounce filter compiled in with GARRAFA_DEBOUNCE_EN.
module modulo_sincroniza_borda #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_garrafa,
  output logic borda
);

  logic s1, s2;
  logic v1, v2;
  logic armado;
  logic nivel;
  logic nivel_ant;

  if (DEB_CYCLES < 2 || DEB_CYCLES > 15) begin : g_deb_range
    $error("DEB_CYCLES out of range 2..15");
  end

  // v1/v2 mark when s2 holds a real sensor sample rather than its reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      armado    <= 1'b0;
      nivel_ant <= 1'b0;
    end else begin
      s1        <= sensor_garrafa;
      s2        <= s1;
      v1        <= 1'b1;
      v2        <= v1;
      nivel_ant <= nivel;
      if (v2 && !s2) armado <= 1'b1;
    end
  end

`ifdef GARRAFA_DEBOUNCE_EN
  localparam logic [3:0] DEB_LIM = 4'(DEB_CYCLES - 1);
  logic [3:0] deb_cnt;
  logic       filt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt    <= 1'b0;
      deb_cnt <= 4'd0;
    end else if (s2 == filt) begin
      deb_cnt <= 4'd0;
    end else if (deb_cnt == DEB_LIM) begin
      filt    <= s2;
      deb_cnt <= 4'd0;
    end else begin
      deb_cnt <= deb_cnt + 4'd1;
    end
  end

  assign nivel = filt;
`else
  assign nivel = s2;
`endif

  assign borda = armado & nivel & ~nivel_ant;

endmodule

// File: rtl/modulo_contador_garrafas.sv
// rtl/modulo_contador_garrafas.sv - two-digit BCD bottle counter with box-full handshake
// Optional sensor debounce selected by GARRAFA_DEBOUNCE_EN.
module modulo_contador_garrafas
  import garrafas_pkg::*;
#(
  parameter int MAX_GARRAFAS = MAX_GARRAFAS_PADRAO,
  parameter int DEB_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_garrafa,
  input  logic       habilita,
  input  logic       caixa_retirada,
  output logic [3:0] cdd_u,
  output logic [3:0] cdd_d,
  output logic       caixa_cheia,
  output logic       garrafa_contada,
  output logic       erro_excesso
);

  localparam bcd2_t MAX_BCD = int2bcd(MAX_GARRAFAS);

  if (MAX_GARRAFAS < 1 || MAX_GARRAFAS > 99) begin : g_max_range
    $error("MAX_GARRAFAS out of range 1..99");
  end

  estado_t estado;
  bcd2_t   cont;
  bcd2_t   prox;
  logic    borda;

  modulo_sincroniza_borda #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sinc (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor_garrafa(sensor_garrafa),
    .borda         (borda)
  );

  assign prox = bcd_inc(cont);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado          <= CONTANDO;
      cont            <= '0;
      caixa_cheia     <= 1'b0;
      garrafa_contada <= 1'b0;
      erro_excesso    <= 1'b0;
    end else begin
      garrafa_contada <= 1'b0;
      case (estado)
        CONTANDO: begin
          if (borda && habilita) begin
            cont            <= prox;
            garrafa_contada <= 1'b1;
            if (prox == MAX_BCD) begin
              estado      <= CHEIA;
              caixa_cheia <= 1'b1;
            end
          end
        end
        CHEIA: begin
          if (caixa_retirada) begin
            cont        <= '0;
            caixa_cheia <= 1'b0;
            estado      <= CONTANDO;
          end
          // A bottle arriving on a full box wins over the clear from removal.
          if (borda) erro_excesso <= 1'b1;
          else if (caixa_retirada) erro_excesso <= 1'b0;
        end
        default: estado <= CONTANDO;
      endcase
    end
  end

  assign cdd_u = cont.u;
  assign cdd_d = cont.d;

endmodule

// File: tb/tb_modulo_contador_garrafas.sv
// tb/tb_modulo_contador_garrafas.sv - directed self-checking bench for modulo_contador_garrafas
// Runs capacity-12 and capacity-99 instances side by side; debounce checks under GARRAFA_DEBOUNCE_EN.
module tb_modulo_contador_garrafas;

  localparam int DEB = 4;
`ifdef GARRAFA_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
  localparam int HI  = 6;
  localparam int LO  = 6;
`else
  localparam int LAT = 2;
  localparam int HI  = 2;
  localparam int LO  = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor_garrafa;
  logic       habilita;
  logic       caixa_retirada;
  logic [3:0] u12, d12, u99, d99;
  logic       cheia12, cont12, erro12;
  logic       cheia99, cont99, erro99;

  int checks = 0;
  int failures = 0;

  modulo_contador_garrafas #(.MAX_GARRAFAS(12), .DEB_CYCLES(DEB)) dut12 (
    .clk(clk), .rst_n(rst_n), .sensor_garrafa(sensor_garrafa), .habilita(habilita),
    .caixa_retirada(caixa_retirada), .cdd_u(u12), .cdd_d(d12), .caixa_cheia(cheia12),
    .garrafa_contada(cont12), .erro_excesso(erro12)
  );

  modulo_contador_garrafas #(.MAX_GARRAFAS(99), .DEB_CYCLES(DEB)) dut99 (
    .clk(clk), .rst_n(rst_n), .sensor_garrafa(sensor_garrafa), .habilita(habilita),
    .caixa_retirada(caixa_retirada), .cdd_u(u99), .cdd_d(d99), .caixa_cheia(cheia99),
    .garrafa_contada(cont99), .erro_excesso(erro99)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bottle();
    sensor_garrafa = 1'b1;
    repeat (HI) tick();
    sensor_garrafa = 1'b0;
    repeat (LO) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    sensor_garrafa = 1'b1;
    habilita = 1'b1;
    caixa_retirada = 1'b0;
    repeat (3) tick();
    chk("rst_u", u12, 0);
    chk("rst_d", d12, 0);
    chk("rst_cheia", cheia12, 0);
    chk("rst_contada", cont12, 0);
    chk("rst_erro", erro12, 0);

    // sensor high through reset release must not count
    rst_n = 1'b1;
    repeat (10) tick();
    chk("high_at_reset_u", u12, 0);
    sensor_garrafa = 1'b0;
    repeat (LO) tick();
    sensor_garrafa = 1'b1;
    repeat (LAT) tick();
    chk("first_pre_u", u12, 0);
    tick();
    chk("first_u", u12, 1);
    chk("first_pulse", cont12, 1);
    tick();
    chk("first_pulse_end", cont12, 0);
    sensor_garrafa = 1'b0;
    repeat (LO) tick();

    for (int i = 2; i <= 11; i++) begin
      bottle();
      chk($sformatf("seq_u_%0d", i), u12, i % 10);
      chk($sformatf("seq_d_%0d", i), d12, i / 10);
    end
    chk("cheia_at_11", cheia12, 0);

    sensor_garrafa = 1'b1;
    repeat (LAT) tick();
    chk("cheia_before_12", cheia12, 0);
    tick();
    chk("cheia_at_12", cheia12, 1);
    chk("u_at_12", u12, 2);
    chk("d_at_12", d12, 1);
    sensor_garrafa = 1'b0;
    repeat (LO) tick();

    bottle();
    chk("excess_u", u12, 2);
    chk("excess_d", d12, 1);
    chk("excess_erro", erro12, 1);
    caixa_retirada = 1'b1;
    tick();
    caixa_retirada = 1'b0;
    chk("removed_u", u12, 0);
    chk("removed_d", d12, 0);
    chk("removed_cheia", cheia12, 0);
    chk("removed_erro", erro12, 0);

    repeat (12) bottle();
    chk("refill_cheia", cheia12, 1);
    sensor_garrafa = 1'b1;
    repeat (LAT) tick();
    caixa_retirada = 1'b1;
    tick();
    caixa_retirada = 1'b0;
    chk("simul_u", u12, 0);
    chk("simul_d", d12, 0);
    chk("simul_cheia", cheia12, 0);
    chk("simul_erro", erro12, 1);
    sensor_garrafa = 1'b0;
    repeat (LO) tick();

    habilita = 1'b0;
    repeat (3) bottle();
    chk("disabled_u", u12, 0);
    chk("disabled_cheia", cheia12, 0);
    habilita = 1'b1;
    repeat (7) bottle();
    chk("seven_u", u12, 7);
    chk("seven_d", d12, 0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_u", u12, 0);
    chk("mid_rst_d", d12, 0);
    chk("mid_rst_cheia", cheia12, 0);
    chk("mid_rst_contada", cont12, 0);
    chk("mid_rst_erro", erro12, 0);
    rst_n = 1'b1;
    repeat (4) tick();

`ifdef GARRAFA_DEBOUNCE_EN
    sensor_garrafa = 1'b1;
    repeat (2) tick();
    sensor_garrafa = 1'b0;
    repeat (8) tick();
    chk("glitch_u", u12, 0);
    sensor_garrafa = 1'b1;
    repeat (LAT) tick();
    chk("deb_pre_u", u12, 0);
    tick();
    chk("deb_u", u12, 1);
    sensor_garrafa = 1'b0;
    repeat (LO) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
`endif

    for (int i = 1; i <= 99; i++) begin
      bottle();
      if (i == 98) chk("cheia99_at_98", cheia99, 0);
    end
    chk("full99_u", u99, 9);
    chk("full99_d", d99, 9);
    chk("full99_cheia", cheia99, 1);
    chk("over12_u", u12, 2);
    chk("over12_d", d12, 1);
    chk("over12_erro", erro12, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
